gol_generation_sequencer: RTL

- Control stage directly upstream of the Game-of-Life wrapper; sits between the HPS PIO command registers and the wrapper's initialize/completed handshake.
- Runs N consecutive generations without HPS involvement, ping-ponging the wrapper's starting/result addresses between two on-chip-memory board buffers.
- Reports progress, the buffer holding the final board, and completion back to HPS PIOs.

---
 rtl/gol_pkg.sv | 21 ++
 rtl/gol_edge_detect.sv | 21 ++
 rtl/gol_generation_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// gol_pkg: shared state encoding, width defaults and default board buffer
// bases for the Game-of-Life generation sequencer and its helpers.
package gol_pkg;

   localparam int GOL_ADDR_W = 12;
   localparam int GOL_CNT_W  = 16;

   localparam logic [GOL_ADDR_W-1:0] GOL_BASE_A_DEF = 12'h000;
   localparam logic [GOL_ADDR_W-1:0] GOL_BASE_B_DEF = 12'h100;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LAUNCH   = 3'd1,
      ST_WAIT_CPL = 3'd2,
      ST_WAIT_REL = 3'd3,
      ST_NEXT     = 3'd4,
      ST_DRAIN    = 3'd5,
      ST_FINISH   = 3'd6
   } gol_state_e;

endpackage

// File: rtl/gol_edge_detect.sv
// gol_edge_detect: rising-edge detector for a level strobe coming from an
// HPS PIO register. The delay register resets high, so a level that is
// already high when reset is released is not taken as a fresh edge.
module gol_edge_detect (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   // one-cycle delay of the strobe level
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sig_q <= 1'b1;
      else       sig_q <= sig_i;
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/gol_generation_sequencer.sv
// gol_generation_sequencer: runs N Game-of-Life generations back to back,
// ping-ponging the wrapper's starting/result addresses between buffers A
// and B, and reports progress, final buffer and completion to the HPS.
// Optional per-generation watchdog: define GOL_SEQ_TIMEOUT_EN.
module gol_generation_sequencer
   import gol_pkg::*;
#(
   parameter int ADDR_W         = GOL_ADDR_W,
   parameter int CNT_W          = GOL_CNT_W,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_cmd_go,
   input  logic              io_cmd_abort,
   input  logic [ADDR_W-1:0] io_base_addr_a,
   input  logic [ADDR_W-1:0] io_base_addr_b,
   input  logic [CNT_W-1:0]  io_gen_count,
   output logic [ADDR_W-1:0] io_gol_starting_address,
   output logic [ADDR_W-1:0] io_gol_result_address,
   output logic              io_gol_initialize,
   input  logic              io_gol_completed,
   output logic              io_busy,
   output logic              io_done,
   output logic              io_aborted,
   output logic [CNT_W-1:0]  io_gens_done,
   output logic [ADDR_W-1:0] io_final_addr
`ifdef GOL_SEQ_TIMEOUT_EN
   ,
   output logic              io_timeout
`endif
);

   gol_state_e        state_q, state_d;
   logic              go_rise, accept, wd_expire;
   logic              init_q, init_d, busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
   logic [CNT_W-1:0]  gens_q, gens_d, cnt_q, cnt_d;
   logic [ADDR_W-1:0] final_q, final_d, start_q, start_d, result_q, result_d;
   logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d, src_q, src_d, dst_q, dst_d;

   gol_edge_detect u_go_edge (
      .clk_i  (clock),
      .rst_i  (reset),
      .sig_i  (io_cmd_go),
      .rise_o (go_rise)
   );

   assign accept = go_rise && (state_q == ST_IDLE || state_q == ST_FINISH);

`ifdef GOL_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q;
   logic            timeout_q;

   assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   // watchdog: restarts in LAUNCH, counts WAIT_CPL cycles; sticky flag until next run
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == ST_LAUNCH)        wd_q <= '0;
         else if (state_q == ST_WAIT_CPL) wd_q <= wd_q + 1'b1;
         if (accept) timeout_q <= 1'b0;
         else if (state_q == ST_WAIT_CPL && !io_gol_completed && wd_expire) timeout_q <= 1'b1;
      end
   end

   assign io_timeout = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign wd_expire          = 1'b0;
`endif

   // state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // next-state logic; completion takes priority over abort/timeout in WAIT_CPL
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_FINISH: if (go_rise) state_d = (io_gen_count == '0) ? ST_FINISH : ST_LAUNCH;
         ST_LAUNCH:          state_d = io_cmd_abort ? ST_DRAIN : ST_WAIT_CPL;
         ST_WAIT_CPL: begin
            if (io_gol_completed)               state_d = ST_WAIT_REL;
            else if (io_cmd_abort || wd_expire) state_d = ST_DRAIN;
         end
         ST_WAIT_REL: begin
            if (io_cmd_abort)           state_d = ST_DRAIN;
            else if (!io_gol_completed) state_d = ST_NEXT;
         end
         ST_NEXT:            state_d = (gens_q == cnt_q) ? ST_FINISH : ST_LAUNCH;
         ST_DRAIN:           if (!io_gol_completed) state_d = ST_FINISH;
         default:            state_d = ST_IDLE;
      endcase
   end

   // next values of the registered outputs and the per-run latches
   always_comb begin
      init_d    = init_q;
      busy_d    = busy_q;
      done_d    = done_q;
      aborted_d = aborted_q;
      gens_d    = gens_q;
      final_d   = final_q;
      start_d   = start_q;
      result_d  = result_q;
      base_a_d  = base_a_q;
      base_b_d  = base_b_q;
      cnt_d     = cnt_q;
      src_d     = src_q;
      dst_d     = dst_q;
      case (state_q)
         ST_IDLE, ST_FINISH: begin
            if (go_rise) begin
               base_a_d  = io_base_addr_a;
               base_b_d  = io_base_addr_b;
               cnt_d     = io_gen_count;
               src_d     = io_base_addr_a;
               dst_d     = io_base_addr_b;
               final_d   = io_base_addr_a;
               gens_d    = '0;
               aborted_d = 1'b0;
               if (io_gen_count == '0) begin
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  busy_d   = 1'b1;
                  done_d   = 1'b0;
                  start_d  = io_base_addr_a;
                  result_d = io_base_addr_b;
               end
            end
         end
         ST_LAUNCH: begin
            if (io_cmd_abort) aborted_d = 1'b1;
            else              init_d    = 1'b1;
         end
         ST_WAIT_CPL: begin
            if (io_gol_completed) begin
               init_d  = 1'b0;
               gens_d  = gens_q + 1'b1;
               final_d = dst_q;
            end else if (io_cmd_abort || wd_expire) begin
               init_d    = 1'b0;
               aborted_d = 1'b1;
            end
         end
         ST_WAIT_REL: if (io_cmd_abort) aborted_d = 1'b1;
         ST_NEXT: begin
            final_d = dst_q;
            src_d   = dst_q;
            dst_d   = src_q;
            if (gens_q == cnt_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end else begin
               start_d  = dst_q;
               result_d = src_q;
            end
         end
         ST_DRAIN: begin
            if (!io_gol_completed) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         init_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         gens_q    <= '0;
         final_q   <= '0;
         start_q   <= '0;
         result_q  <= '0;
      end else begin
         init_q    <= init_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         gens_q    <= gens_d;
         final_q   <= final_d;
         start_q   <= start_d;
         result_q  <= result_d;
      end
   end

   // per-run latches; only meaningful after an accepted go, so no reset
   always_ff @(posedge clock) begin
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
   end

   assign io_gol_starting_address = start_q;
   assign io_gol_result_address   = result_q;
   assign io_gol_initialize       = init_q;
   assign io_busy                 = busy_q;
   assign io_done                 = done_q;
   assign io_aborted              = aborted_q;
   assign io_gens_done            = gens_q;
   assign io_final_addr           = final_q;

endmodule
